// File: rtl/bist_pkg.sv
// Shared types and default sizing for the adder BIST controller.
package bist_pkg;

    localparam int WIDTH = 6;
    localparam int VEC_W = 2 * WIDTH;
    localparam int SUM_W = WIDTH + 1;
    localparam int N_VEC = 1 << VEC_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        APPLY = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } bist_state_e;

endpackage

// File: rtl/bist_golden_add.sv
// Reference sum for the BIST checker; kept apart from the adder under test.
module bist_golden_add
    import bist_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH:0]   sum
);

    assign sum = {1'b0, x} + {1'b0, y};

endmodule

// File: rtl/adder_bist_ctrl.sv
// Exhaustive operand sweep for the ripple adder with mismatch counting.
// state | meaning
// IDLE  | waiting for start
// APPLY | drive operands from idx, load settle counter
// WAIT  | settle window, SETTLE cycles
// CHECK | sample s_in against golden sum, advance idx
// DONE  | results held until next start
module adder_bist_ctrl
    import bist_pkg::*;
#(
    parameter int WIDTH  = 6,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     x_out,
    output logic [WIDTH-1:0]     y_out,
    input  logic [WIDTH:0]       s_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_count,
    output logic [2*WIDTH-1:0]   first_err_idx,
    output logic                 err_pulse,
    output logic [2*WIDTH-1:0]   cur_idx
);

    localparam int IW = 2 * WIDTH;
    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] WAIT_LOAD = CW'(SETTLE);
    localparam logic [CW-1:0] WAIT_ONE  = CW'(1);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic [IW:0]   CNT_ONE   = (IW + 1)'(1);

    bist_state_e     state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic [IW:0]     err_cnt_q, err_cnt_d;
    logic [IW-1:0]   first_idx_q, first_idx_d;
    logic            first_seen_q, first_seen_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            err_pulse_q, err_pulse_d;
    logic [WIDTH:0]  exp_sum;
    logic            mismatch;

    bist_golden_add #(.WIDTH(WIDTH)) u_golden (
        .x   (x_q),
        .y   (y_q),
        .sum (exp_sum)
    );

    assign mismatch = (s_in != exp_sum);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        x_d          = x_q;
        y_d          = y_q;
        wait_d       = wait_q;
        err_cnt_d    = err_cnt_q;
        first_idx_d  = first_idx_q;
        first_seen_d = first_seen_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_pulse_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = APPLY;
                    idx_d        = '0;
                    err_cnt_d    = '0;
                    first_idx_d  = '0;
                    first_seen_d = 1'b0;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                end
            end
            APPLY: begin
                x_d     = idx_q[IW-1:WIDTH];
                y_d     = idx_q[WIDTH-1:0];
                wait_d  = WAIT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                wait_d = wait_q - WAIT_ONE;
                if (wait_q == WAIT_ONE) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    err_cnt_d   = err_cnt_q + CNT_ONE;
                    err_pulse_d = 1'b1;
                    if (!first_seen_q) begin
                        first_idx_d  = idx_q;
                        first_seen_d = 1'b1;
                    end
                end
                // The terminal vector exits instead of wrapping idx.
                if (idx_q == '1) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == '0);
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = APPLY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            wait_q       <= '0;
            err_cnt_q    <= '0;
            first_idx_q  <= '0;
            first_seen_q <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            x_q          <= x_d;
            y_q          <= y_d;
            wait_q       <= wait_d;
            err_cnt_q    <= err_cnt_d;
            first_idx_q  <= first_idx_d;
            first_seen_q <= first_seen_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_pulse_q  <= err_pulse_d;
        end
    end

    assign x_out         = x_q;
    assign y_out         = y_q;
    assign busy          = (state_q == APPLY) || (state_q == WAIT) || (state_q == CHECK);
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_cnt_q;
    assign first_err_idx = first_idx_q;
    assign err_pulse     = err_pulse_q;
    assign cur_idx       = idx_q;

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Bench for adder_bist_ctrl: adder models with planted faults, sweep-level scoreboard.
module tb_adder_bist_ctrl;

    typedef struct {
        int errs;
        int first;
        int pass;
        int cycles;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start     [2];
    logic [5:0]  x_o       [2];
    logic [5:0]  y_o       [2];
    logic [6:0]  s_i       [2];
    logic        busy      [2];
    logic        done      [2];
    logic        pass_o    [2];
    logic [12:0] err_count [2];
    logic [11:0] first_err [2];
    logic        err_pulse [2];
    logic [11:0] cur_idx   [2];
    logic [11:0] dly_a     [2];
    logic [11:0] dly_b     [2];
    int          mode      [2];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   bcnt    [2];
    int   pcnt    [2];
    int   sweeps  [2];
    logic done_d  [2];
    exp_t sbq0[$];
    exp_t sbq1[$];

    always #5 clk = ~clk;

    adder_bist_ctrl #(.WIDTH(6), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start[0]),
        .x_out(x_o[0]), .y_out(y_o[0]), .s_in(s_i[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass_o[0]),
        .err_count(err_count[0]), .first_err_idx(first_err[0]),
        .err_pulse(err_pulse[0]), .cur_idx(cur_idx[0])
    );

    adder_bist_ctrl #(.WIDTH(6), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start[1]),
        .x_out(x_o[1]), .y_out(y_o[1]), .s_in(s_i[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass_o[1]),
        .err_count(err_count[1]), .first_err_idx(first_err[1]),
        .err_pulse(err_pulse[1]), .cur_idx(cur_idx[1])
    );

    // mode 0 good, 1 s[0] stuck-at-0, 2 cout stuck-at-0, 3 output valid 2 cycles late
    function automatic logic [6:0] adder_model(input int md, input logic [5:0] x,
                                               input logic [5:0] y, input logic [11:0] dl);
        logic [6:0] s_now;
        logic [6:0] s_dly;
        s_now = {1'b0, x} + {1'b0, y};
        s_dly = {1'b0, dl[11:6]} + {1'b0, dl[5:0]};
        case (md)
            1:       return s_now & 7'h7E;
            2:       return s_now & 7'h3F;
            3:       return s_dly;
            default: return s_now;
        endcase
    endfunction

    assign s_i[0] = adder_model(mode[0], x_o[0], y_o[0], dly_b[0]);
    assign s_i[1] = adder_model(mode[1], x_o[1], y_o[1], dly_b[1]);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_a[0] <= '0; dly_b[0] <= '0;
            dly_a[1] <= '0; dly_b[1] <= '0;
        end else begin
            dly_a[0] <= {x_o[0], y_o[0]}; dly_b[0] <= dly_a[0];
            dly_a[1] <= {x_o[1], y_o[1]}; dly_b[1] <= dly_a[1];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // Independent sweep model: what the adder returns for each vector and what the
    // controller should therefore accumulate.
    function automatic exp_t model(input int md, input int settle, input int prev);
        exp_t e;
        int   p;
        bit   found;
        p = prev;
        found = 1'b0;
        e.errs = 0;
        e.first = 0;
        for (int k = 0; k < 4096; k++) begin
            int x, y, good, obs;
            x = k / 64;
            y = k % 64;
            good = x + y;
            if (md == 3 && settle < 2) obs = p;
            else if (md == 1)          obs = good & 'h7E;
            else if (md == 2)          obs = good & 'h3F;
            else                       obs = good;
            p = good;
            if (obs != good) begin
                e.errs++;
                if (!found) begin
                    e.first = k;
                    found = 1'b1;
                end
            end
        end
        e.pass = (e.errs == 0) ? 1 : 0;
        e.cycles = 4096 * (settle + 2);
        return e;
    endfunction

    task automatic pulse_start(input int d);
        @(posedge clk);
        #1 start[d] = 1'b1;
        @(posedge clk);
        #1 start[d] = 1'b0;
    endtask

    task automatic start_sweep(input int d, input int md, input int settle, input int prev);
        mode[d] = md;
        if (d == 0) sbq0.push_back(model(md, settle, prev));
        else        sbq1.push_back(model(md, settle, prev));
        pulse_start(d);
    endtask

    task automatic wait_sweep(input int d, input int budget);
        int target;
        int n;
        target = sweeps[d] + 1;
        n = 0;
        while (sweeps[d] < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sweeps[d] < target) chk($sformatf("d%0d_sweep_timeout", d), sweeps[d], target);
    endtask

    // Scoreboard: pop the expected sweep result when done rises.
    initial begin
        for (int d = 0; d < 2; d++) begin
            bcnt[d] = 0; pcnt[d] = 0; sweeps[d] = 0; done_d[d] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                exp_t e;
                int   qs;
                if (!rst_n) begin
                    bcnt[d] = 0;
                    pcnt[d] = 0;
                    done_d[d] = 1'b0;
                end else begin
                    if (busy[d]) bcnt[d]++;
                    if (err_pulse[d]) pcnt[d]++;
                    if (done[d] && !done_d[d]) begin
                        qs = (d == 0) ? sbq0.size() : sbq1.size();
                        if (qs == 0) begin
                            chk($sformatf("d%0d_sb_pending", d), qs, 1);
                        end else begin
                            e = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
                            chk($sformatf("d%0d_err_count", d), err_count[d], e.errs);
                            chk($sformatf("d%0d_first_err_idx", d), first_err[d], e.first);
                            chk($sformatf("d%0d_pass", d), pass_o[d], e.pass);
                            chk($sformatf("d%0d_busy_cycles", d), bcnt[d], e.cycles);
                            chk($sformatf("d%0d_err_pulses", d), pcnt[d], e.errs);
                        end
                        bcnt[d] = 0;
                        pcnt[d] = 0;
                        sweeps[d]++;
                    end
                    done_d[d] = done[d];
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        start[0] = 1'b0;
        start[1] = 1'b0;
        mode[0]  = 0;
        mode[1]  = 3;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_state", {x_o[0], y_o[0], busy[0], done[0], pass_o[0], err_count[0],
                            first_err[0], err_pulse[0], cur_idx[0]}, 64'd0);

        fork
            begin
                start_sweep(0, 0, 1, 0);
                wait_sweep(0, 12400);
                start_sweep(0, 1, 1, 0);
                wait_sweep(0, 12400);
                start_sweep(0, 2, 1, 0);
                wait_sweep(0, 12400);
            end
            begin
                start_sweep(1, 3, 3, 0);
                wait_sweep(1, 20600);
                start_sweep(1, 3, 3, 0);
                chk("d1_rerun_cleared", {done[1], pass_o[1], err_count[1], first_err[1]}, 64'd0);
                chk("d1_rerun_busy", busy[1], 1);
                wait_sweep(1, 20600);
            end
        join

        // Asynchronous reset mid-sweep, no clock edge between assertion and check.
        mode[0] = 0;
        pulse_start(0);
        repeat (4998) @(posedge clk);
        #1;
        chk("pre_reset_busy", busy[0], 1);
        rst_n = 1'b0;
        #2;
        chk("async_reset_outputs", {x_o[0], y_o[0], busy[0], done[0], pass_o[0], err_count[0],
                                    first_err[0], err_pulse[0], cur_idx[0]}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_after_reset", {busy[0], done[0], cur_idx[0]}, 64'd0);
        start_sweep(0, 0, 1, 0);
        wait_sweep(0, 12400);

        // Start pulses during a sweep must not restart it.
        start_sweep(0, 0, 1, 0);
        repeat (8) @(posedge clk);
        #1 start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        repeat (5989) @(posedge clk);
        #1 start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        chk("ignored_start_busy", busy[0], 1);
        wait_sweep(0, 12400);

        // Late adder with a one-cycle settle window reads the previous vector's sum.
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        start_sweep(0, 3, 1, 0);
        wait_sweep(0, 12400);

        repeat (5) @(negedge clk);
        chk("sb_drained", sbq0.size() + sbq1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
